// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the reg_file register bank.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } reg_file_state_t;

  function automatic int unsigned reg_file_aw(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_clr_ctrl.sv
// Clear sequencer for reg_file: walks the sweep counter across every entry,
// one per cycle, and pulses o_clr_done once the last entry has been written.
module reg_file_clr_ctrl
  import reg_file_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = reg_file_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic          o_clr_done,
  output logic [AW-1:0] o_sweep_addr,
  output logic          o_sweep_we
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  reg_file_state_t r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_done, w_done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // clr_req is only looked at in IDLE, so a request during a sweep is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy       = (r_state == CLEAR);
  assign o_sweep_we   = (r_state == CLEAR);
  assign o_sweep_addr = r_cnt;
  assign o_clr_done   = r_done;

endmodule

// File: rtl/reg_file.sv
// Multi-entry register file: one write port, two combinational read ports,
// command-driven clear sweep. Optional write-first bypass: REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int unsigned      WIDTH    = 8,
  parameter  int unsigned      DEPTH    = 8,
  parameter  logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int unsigned      AW       = reg_file_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done,
  output logic             wr_err
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_wr_err;

  logic             w_busy;
  logic             w_sweep_we;
  logic [AW-1:0]    w_sweep_addr;
  logic             w_waddr_ok;
  logic             w_raddr_a_ok;
  logic             w_raddr_b_ok;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rdata_a;
  logic [WIDTH-1:0] w_rdata_b;

  reg_file_clr_ctrl #(
    .DEPTH(DEPTH)
  ) u_clr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_clr_req   (clr_req),
    .o_busy      (w_busy),
    .o_clr_done  (clr_done),
    .o_sweep_addr(w_sweep_addr),
    .o_sweep_we  (w_sweep_we)
  );

  // A power-of-two depth makes every address legal; skip the range compare.
  generate
    if (DEPTH == (1 << AW)) begin : g_full_range
      assign w_waddr_ok   = 1'b1;
      assign w_raddr_a_ok = 1'b1;
      assign w_raddr_b_ok = 1'b1;
    end else begin : g_part_range
      localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
      assign w_waddr_ok   = ({1'b0, waddr}   < DEPTH_W);
      assign w_raddr_a_ok = ({1'b0, raddr_a} < DEPTH_W);
      assign w_raddr_b_ok = ({1'b0, raddr_b} < DEPTH_W);
    end
  endgenerate

  assign w_wr_ok = we && !w_busy && w_waddr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INIT_VAL;
      end
    end else if (w_sweep_we) begin
      r_mem[w_sweep_addr] <= INIT_VAL;
    end else if (w_wr_ok) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= we && !w_wr_ok;
    end
  end

  always_comb begin
    w_rdata_a = w_raddr_a_ok ? r_mem[raddr_a] : '0;
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_ok && (raddr_a == waddr)) begin
      w_rdata_a = wdata;
    end
`endif
  end

  always_comb begin
    w_rdata_b = w_raddr_b_ok ? r_mem[raddr_b] : '0;
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_ok && (raddr_b == waddr)) begin
      w_rdata_b = wdata;
    end
`endif
  end

  assign rdata_a = w_rdata_a;
  assign rdata_b = w_rdata_b;
  assign busy    = w_busy;
  assign wr_err  = r_wr_err;

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Parametrised multi-entry register file for FSM-D datapaths.
- One write port, two combinational read ports.
- A command-driven clear sequencer sweeps every entry back to a programmable init value, one entry per cycle.
- Replaces ad-hoc banks of single enabled registers when a datapath needs addressable storage.

Parameters:
- WIDTH, 8, data width of each entry in bits.
- DEPTH, 8, number of entries; any value >= 2, need not be a power of two.
- INIT_VAL, 0, WIDTH-bit value loaded into entries on reset and by the clear sweep.
- Derived localparam AW = $clog2(DEPTH), address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- raddr_a  input  AW  read address, port A.
- rdata_a  output  WIDTH  read data, port A (combinational).
- raddr_b  input  AW  read address, port B.
- rdata_b  output  WIDTH  read data, port B (combinational).
- clr_req  input  1  single-cycle request to start a clear sweep.
- busy  output  1  high while the clear sweep is active.
- clr_done  output  1  one-cycle pulse when the sweep completes.
- wr_err  output  1  registered one-cycle pulse flagging a dropped write.

Behaviour:
- Reset (async, rst=1):
  - All entries = INIT_VAL.
  - FSM = IDLE, sweep counter = 0.
  - busy=0, clr_done=0, wr_err=0.
  - Reset asserted mid-sweep aborts the sweep; every entry reads INIT_VAL, with no clr_done pulse.
- Write:
  - On posedge with we=1, busy=0 and waddr<DEPTH: mem[waddr]<=wdata.
  - The new value is visible on the read ports from the next cycle.
- Dropped write:
  - A write with we=1 and either busy=1 or waddr>=DEPTH is discarded.
  - wr_err=1 in the following cycle only; otherwise wr_err=0.
- Reads:
  - rdata_x = mem[raddr_x] combinationally.
  - raddr_x>=DEPTH gives 0.
  - Both ports may address the same entry.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on posedge with clr_req=1; the counter loads 0.
  - In CLEAR, each posedge writes mem[cnt]<=INIT_VAL and increments cnt.
  - When the cnt=DEPTH-1 entry is written: -> IDLE, and clr_done=1 for exactly that following cycle.
- Sweep timing:
  - busy=1 from the cycle after clr_req is sampled, for exactly DEPTH cycles.
  - busy falls in the same cycle clr_done rises.
- Sweep boundary rules:
  - clr_req while busy=1 is ignored (no restart, no error).
  - clr_req together with we in IDLE: the write is performed that edge, then the sweep overwrites it.
  - During CLEAR, reads return current contents: swept entries read INIT_VAL, unswept entries keep their old data.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined: write-first read bypass. When we=1, busy=0, waddr<DEPTH and raddr_x==waddr, rdata_x returns wdata in the same cycle.
- Undefined: rdata_x returns the stored (pre-write) value until the next cycle.
- The bypass never applies to sweep writes or dropped writes.

Decomposition:
- reg_file_pkg holds:
  - typedef enum logic {IDLE, CLEAR} reg_file_state_t.
  - localparam helper function for the address-width computation.
- Sub-module reg_file_clr_ctrl holds the FSM and sweep counter.
  - Outputs: busy, clr_done, sweep address, sweep write-enable.
  - reg_file holds the storage array, the write/read muxing and wr_err.

Test Plan:
- Reset then read all addresses, WIDTH=8 DEPTH=8 INIT_VAL=8'hA5 -> every rdata_a/b = 8'hA5; busy=0, clr_done=0, wr_err=0.
- Write 8'h3C to addr 5, then raddr_a=5 and raddr_b=5 next cycle -> both return 8'h3C.
  - Same-cycle read returns 8'hA5 without REG_FILE_BYPASS_EN, 8'h3C with it.
- Fill entries 0..7 with 8'h10..8'h17, pulse clr_req:
  - busy high for exactly 8 cycles; clr_done pulses once as busy falls.
  - Mid-sweep, after 3 entries are swept, entry 2 reads 8'hA5 and entry 6 reads 8'h16.
  - Afterwards all entries read 8'hA5.
- Write during sweep (we=1, waddr=1, wdata=8'hFF at busy=1) -> entry 1 unchanged, wr_err=1 the next cycle only.
  - A second clr_req mid-sweep causes no restart; the total busy length stays 8 cycles.
- DEPTH=6: write to addr 7 -> wr_err pulse, no entry changes; raddr_a=6 -> rdata_a=0.
- Assert rst at sweep cycle 4 with entries previously 8'h10..8'h17 -> all entries 8'hA5 immediately, busy=0, no clr_done.
  - After rst drops, normal writes are accepted.
